// File: rtl/layer_4_conv_sequencer.sv
// ---------------------------------------------------------------------------
// layer_4_conv_sequencer
//
// Sequences one layer-4 convolution stage. Each output-channel pass loads its
// weight bank, raster-scans the IMG_SIZE x IMG_SIZE input buffer and feeds the
// featuremap engines. It then counts the engines' result pulses until the pass
// is complete. done pulses once after the last pass has drained.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   start_i      start a layer (only looked at while idle)
//   fm_ready_i   engines accept a pixel this cycle
//   valid_out_i  one pixel result from the engines
//   rd_en_o      input buffer read strobe
//   rd_addr_o    input buffer read address (row*IMG_SIZE + col)
//   valid_in_o   rd_en_o delayed by RD_LATENCY cycles
//   pass_idx_o   current pass / weight bank select
//   w_load_o     one-cycle weight bank load request
//   busy_o       high from leaving idle until done
//   done_o       one-cycle pulse after the last pass drains
//   ovf_err_o    sticky: unexpected or excess valid_out_i
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start_i
// LOAD   | weight bank loading, W_LOAD_CYCLES cycles, w_load on entry
// STREAM | issuing reads while fm_ready_i, until last address
// DRAIN  | all reads issued, waiting for the remaining valid_out_i
// DONE   | single cycle with done_o high, then back to IDLE
// ---------------------------------------------------------------------------
module layer_4_conv_sequencer #(
   parameter int IMG_SIZE      = 104,
   parameter int ADDR_WIDTH    = 14,
   parameter int NUM_PASSES    = 8,
   parameter int PASS_WIDTH    = 3,
   parameter int RD_LATENCY    = 1,
   parameter int W_LOAD_CYCLES = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic                  fm_ready_i,
   input  logic                  valid_out_i,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic                  valid_in_o,
   output logic [PASS_WIDTH-1:0] pass_idx_o,
   output logic                  w_load_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ovf_err_o
);

   localparam int NPIX  = IMG_SIZE * IMG_SIZE;
   localparam int CNT_W = $clog2(NPIX) + 1;
   localparam int TMR_W = (W_LOAD_CYCLES > 1) ? $clog2(W_LOAD_CYCLES) : 1;

   localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(NPIX);
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(NPIX - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NPIX - 1);
   localparam logic [PASS_WIDTH-1:0] PASS_LAST = PASS_WIDTH'(NUM_PASSES - 1);
   localparam logic [TMR_W-1:0]      TMR_INIT  = TMR_W'(W_LOAD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                  state_q;
   logic [TMR_W-1:0]        load_tmr_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [CNT_W-1:0]        out_cnt_q;
   logic [PASS_WIDTH-1:0]   pass_q;
   logic [RD_LATENCY-1:0]   vin_sr_q;
   logic                    w_load_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    ovf_q;

   logic rd_en;
   logic count_win;
   logic cnt_full;
   logic drain_done;
   logic ovf_d;

   // Reads follow fm_ready_i combinationally so a stall costs no extra cycle
   // and the held address is re-presented as soon as the engines accept.
   assign rd_en     = (state_q == S_STREAM) && fm_ready_i;
   assign count_win = (state_q == S_STREAM) || (state_q == S_DRAIN);
   assign cnt_full  = (out_cnt_q == CNT_FULL);

   // Leave DRAIN on the edge that closes the final valid_out_i, or at once if
   // the count was already complete when the last read went out.
   assign drain_done = cnt_full || (valid_out_i && (out_cnt_q == CNT_LAST));

   // A result outside the counting window or past a full count is an error.
   // Set wins over the clear-on-start so a coincident stray pulse is not lost.
   assign ovf_d = (valid_out_i && (!count_win || cnt_full)) ||
                  (ovf_q && !((state_q == S_IDLE) && start_i));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         load_tmr_q <= '0;
         addr_q     <= '0;
         out_cnt_q  <= '0;
         pass_q     <= '0;
         vin_sr_q   <= '0;
         w_load_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         w_load_q <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= ovf_d;

         vin_sr_q[0] <= rd_en;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vin_sr_q[i] <= vin_sr_q[i-1];
         end

         if (valid_out_i && count_win && !cnt_full) begin
            out_cnt_q <= out_cnt_q + CNT_W'(1);
         end

         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q    <= S_LOAD;
                  busy_q     <= 1'b1;
                  pass_q     <= '0;
                  w_load_q   <= 1'b1;
                  load_tmr_q <= TMR_INIT;
                  addr_q     <= '0;
                  out_cnt_q  <= '0;
               end
            end
            S_LOAD: begin
               if (load_tmr_q == '0) begin
                  state_q <= S_STREAM;
               end else begin
                  load_tmr_q <= load_tmr_q - TMR_W'(1);
               end
            end
            S_STREAM: begin
               // Linear increment equals row*IMG_SIZE+col with col wrapping.
               // The last address is held so rd_addr stays stable in DRAIN.
               if (rd_en) begin
                  if (addr_q == ADDR_LAST) begin
                     state_q <= S_DRAIN;
                  end else begin
                     addr_q <= addr_q + ADDR_WIDTH'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (drain_done) begin
                  if (pass_q == PASS_LAST) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= S_LOAD;
                     pass_q     <= pass_q + PASS_WIDTH'(1);
                     w_load_q   <= 1'b1;
                     load_tmr_q <= TMR_INIT;
                     addr_q     <= '0;
                     out_cnt_q  <= '0;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               pass_q  <= '0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_en_o    = rd_en;
   assign rd_addr_o  = addr_q;
   assign valid_in_o = vin_sr_q[RD_LATENCY-1];
   assign pass_idx_o = pass_q;
   assign w_load_o   = w_load_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign ovf_err_o  = ovf_q;

endmodule

// File: tb/tb_layer_4_conv_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for layer_4_conv_sequencer (IMG_SIZE=4, NUM_PASSES=2, RD_LATENCY=1,
// W_LOAD_CYCLES=2). The reference model tracks a layer as counts: active
// flag, pass number, load cycles spent, reads issued and results seen, and
// derives every expected output from those counts each cycle. A small
// engine stand-in echoes each valid_in as valid_out five cycles later.
// ---------------------------------------------------------------------------
module tb_layer_4_conv_sequencer;

   localparam int IMG  = 4;
   localparam int NPIX = IMG * IMG;
   localparam int NP   = 2;
   localparam int WLC  = 2;
   localparam int ECHO = 5;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       start_i;
   logic       fm_ready_i;
   logic       valid_out_i;
   logic       rd_en_o;
   logic [3:0] rd_addr_o;
   logic       valid_in_o;
   logic [0:0] pass_idx_o;
   logic       w_load_o;
   logic       busy_o;
   logic       done_o;
   logic       ovf_err_o;

   layer_4_conv_sequencer #(
      .IMG_SIZE      (IMG),
      .ADDR_WIDTH    (4),
      .NUM_PASSES    (NP),
      .PASS_WIDTH    (1),
      .RD_LATENCY    (1),
      .W_LOAD_CYCLES (WLC)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .start_i     (start_i),
      .fm_ready_i  (fm_ready_i),
      .valid_out_i (valid_out_i),
      .rd_en_o     (rd_en_o),
      .rd_addr_o   (rd_addr_o),
      .valid_in_o  (valid_in_o),
      .pass_idx_o  (pass_idx_o),
      .w_load_o    (w_load_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .ovf_err_o   (ovf_err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_done;
   int n_wload;
   bit echo_en = 1'b1;
   bit sched [0:16383];

   // reference model
   bit m_active;
   bit m_done_now;
   bit m_ovf;
   bit m_prev_rd;
   int m_pass;
   int m_load;
   int m_reads;
   int m_outs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit m_stream();
      return m_active && !m_done_now && (m_load >= WLC) && (m_reads < NPIX);
   endfunction

   task automatic model_reset();
      m_active = 0; m_done_now = 0; m_ovf = 0; m_prev_rd = 0;
      m_pass = 0; m_load = 0; m_reads = 0; m_outs = 0;
      for (int i = 0; i < 16384; i++) sched[i] = 1'b0;
   endtask

   task automatic model_update(input bit st, input bit rdy, input bit vo, input bit e_rd);
      bit in_load;
      bit drain;
      if (!m_active) begin
         if (st) begin
            m_active = 1; m_pass = 0; m_load = 0; m_reads = 0; m_outs = 0; m_ovf = 0;
         end
         if (vo) m_ovf = 1;
      end else if (m_done_now) begin
         if (vo) m_ovf = 1;
         m_active = 0; m_done_now = 0; m_pass = 0;
      end else begin
         in_load = (m_load < WLC);
         drain   = !in_load && (m_reads == NPIX);
         if (vo) begin
            if (in_load || m_outs == NPIX) m_ovf = 1;
            else m_outs++;
         end
         if (in_load) m_load++;
         else if (!drain && rdy) m_reads++;
         if (drain && m_outs == NPIX) begin
            if (m_pass == NP - 1) m_done_now = 1;
            else begin
               m_pass++; m_load = 0; m_reads = 0; m_outs = 0;
            end
         end
      end
      m_prev_rd = e_rd;
   endtask

   task automatic check_outputs();
      bit e_rd;
      e_rd = m_stream() && fm_ready_i;
      chk("busy", busy_o, m_active);
      chk("rd_en", rd_en_o, e_rd);
      chk("valid_in", valid_in_o, m_prev_rd);
      chk("w_load", w_load_o, m_active && !m_done_now && m_load == 0);
      chk("done", done_o, m_done_now);
      chk("ovf_err", ovf_err_o, m_ovf);
      chk("pass_idx", pass_idx_o, m_pass);
      if (m_active && !m_done_now && m_reads < NPIX) chk("rd_addr", rd_addr_o, m_reads);
   endtask

   // One clock cycle; called at posedge+1.
   task automatic tick(input bit st, input bit rdy, input bit inj);
      bit e_rd;
      start_i     = st;
      fm_ready_i  = rdy;
      valid_out_i = sched[cyc] | inj;
      @(negedge clk_i);
      check_outputs();
      if (done_o) n_done++;
      if (w_load_o) n_wload++;
      if (echo_en && valid_in_o) sched[cyc + ECHO] = 1'b1;
      e_rd = m_stream() && rdy;
      @(posedge clk_i);
      if (rst_n_i) model_update(st, rdy, valid_out_i, e_rd);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 1, 0);
   endtask

   // mode 0: fm_ready=1; mode 1: random ready, 3-cycle stall at addr 5, stray starts;
   // mode 2: stall at addr 4 of pass 0 while forcing 20 extra valid_out pulses.
   task automatic run_layer(input int mode);
      bit fin;
      int stall_left;
      int inj_left;
      fin = 0; stall_left = 3; inj_left = 20;
      n_done = 0; n_wload = 0;
      tick(1, 1, 0);
      for (int i = 0; i < 600 && !fin; i++) begin
         bit rdy;
         bit st;
         bit inj;
         rdy = 1; st = 0; inj = 0;
         if (mode == 1) begin
            rdy = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 4) == 0);
            if (m_pass == 0 && m_stream() && m_reads == 5 && stall_left > 0) begin
               rdy = 0; stall_left--;
            end
         end
         if (mode == 2 && m_pass == 0 && m_stream() && m_reads == 4 && inj_left > 0) begin
            rdy = 0; inj = 1; inj_left--;
         end
         fin = m_done_now;
         tick(st, rdy, inj);
      end
      chk("layer_finished", fin, 1);
      chk("done_pulses", n_done, 1);
      chk("wload_pulses", n_wload, NP);
   endtask

   task automatic async_reset();
      rst_n_i = 1'b0;
      #1;
      chk("rst_rd_en", rd_en_o, 0);
      chk("rst_rd_addr", rd_addr_o, 0);
      chk("rst_valid_in", valid_in_o, 0);
      chk("rst_pass_idx", pass_idx_o, 0);
      chk("rst_w_load", w_load_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_ovf", ovf_err_o, 0);
      model_reset();
      start_i = 0; fm_ready_i = 0; valid_out_i = 0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      cyc++;
   endtask

   initial begin
      bit reached;
      rst_n_i = 1'b0; start_i = 0; fm_ready_i = 0; valid_out_i = 0;
      n_done = 0; n_wload = 0;
      model_reset();
      @(posedge clk_i);
      #1;
      async_reset();
      idle(3);

      run_layer(0);
      idle(8);
      run_layer(1);
      idle(8);
      run_layer(1);
      idle(8);

      run_layer(2);
      idle(12);
      chk("ovf_sticky", ovf_err_o, 1);
      run_layer(0);
      idle(8);

      // reset during pass 1 at rd_addr 9
      n_done = 0; reached = 0;
      tick(1, 1, 0);
      for (int i = 0; i < 200 && !reached; i++) begin
         if (m_pass == 1 && m_stream() && m_reads == 9) reached = 1;
         else tick(0, 1, 0);
      end
      chk("reached_pass1_addr9", reached, 1);
      async_reset();
      idle(6);
      chk("no_done_after_reset", n_done, 0);
      run_layer(0);
      idle(8);

      // results never arrive: the sequencer waits in drain indefinitely
      echo_en = 0; n_done = 0;
      tick(1, 1, 0);
      idle(60);
      chk("drain_busy", busy_o, 1);
      chk("drain_no_done", n_done, 0);
      echo_en = 1;
      async_reset();
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
